sr_flag_arbiter: RTL and testbench

Shares one bank of NFLAG SR flip-flops (a status/flag register) between NREQ requesters. Each requester asks to set or clear one flag. A round-robin arbiter picks one request at a time. The block then drives a single-cycle S or R pulse into the bank, reads back q on the next cycle and confirms the result to the requester. By construction it never drives S=R=1 on any flag, and it drives at most one flag per cycle.

---
 rtl/sr_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sr_flag_arbiter.sv | 112 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared state encoding and operation codes for the SR flag arbiter
package sr_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        DRIVE = S_DRIVE,
        CHECK = S_CHECK
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so one wrap subtraction is enough
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                id     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin shared access to an SR flag bank with read-back check
module sr_flag_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    localparam int FLAG_W = $clog2(NFLAG),
    localparam int PTR_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*FLAG_W-1:0] idx,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [NFLAG-1:0]       s_out,
    output logic [NFLAG-1:0]       r_out,
    input  logic [NFLAG-1:0]       q_in,
    output logic                   busy
);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_id;
    logic               op_l;
    logic [FLAG_W-1:0]  idx_l;
    logic               range_l;

    logic [NREQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]   arb_id;
    logic               arb_any;

    logic [FLAG_W-1:0]  win_idx;
    logic               win_op;
    logic               win_in_range;
    logic [NFLAG-1:0]   win_sel;
    logic [NFLAG-1:0]   q_sh;
    logic               q_bit;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    always_comb begin
        win_idx      = idx[arb_id*FLAG_W +: FLAG_W];
        win_op       = op[arb_id];
        win_in_range = (int'(win_idx) < NFLAG);
        // out-of-range indices still get granted but drive no flag
        win_sel      = win_in_range ? (NFLAG'(1'b1) << win_idx) : '0;
        q_sh         = q_in >> idx_l;
        q_bit        = q_sh[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win_id  <= '0;
            op_l    <= OP_CLR;
            idx_l   <= '0;
            range_l <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            s_out   <= '0;
            r_out   <= '0;
            busy    <= 1'b0;
        end else begin
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            s_out <= '0;
            r_out <= '0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state   <= DRIVE;
                        busy    <= 1'b1;
                        win_id  <= arb_id;
                        op_l    <= win_op;
                        idx_l   <= win_idx;
                        range_l <= win_in_range;
                        gnt     <= arb_gnt;
                        if (win_op == OP_SET) s_out <= win_sel;
                        else                  r_out <= win_sel;
                        ptr <= (arb_id == PTR_W'(NREQ - 1)) ? '0 : arb_id + 1'b1;
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done[win_id] <= 1'b1;
                    err          <= !range_l || (q_bit != op_l);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed vectors and corner sequences for sr_flag_arbiter
module tb_sr_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, op;
    logic [11:0] idx;
    logic [3:0]  gnt, done;
    logic        err, busy;
    logic [7:0]  s_out, r_out;
    logic [7:0]  q_bank = '0;
    logic [7:0]  stuck0;
    logic [7:0]  q_in;

    logic [1:0]  req2, op2, gnt2, done2;
    logic [5:0]  idx2;
    logic        err2, busy2;
    logic [4:0]  s2, r2;
    logic [4:0]  q2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign q_in = q_bank & ~stuck0;
    assign q2   = '0;

    always @(posedge clk) q_bank <= (q_bank | s_out) & ~r_out;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
        .gnt(gnt), .done(done), .err(err), .s_out(s_out), .r_out(r_out),
        .q_in(q_in), .busy(busy)
    );

    sr_flag_arbiter #(.NREQ(2), .NFLAG(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .op(op2), .idx(idx2),
        .gnt(gnt2), .done(done2), .err(err2), .s_out(s2), .r_out(r2),
        .q_in(q2), .busy(busy2)
    );

    a_sr_excl:  assert property (@(negedge clk) disable iff (!rst_n) (s_out & r_out) == 0)
        else $error("FAIL sva_sr_excl s=%0h r=%0h", s_out, r_out);
    a_one_flag: assert property (@(negedge clk) disable iff (!rst_n) $onehot0(s_out | r_out))
        else $error("FAIL sva_one_flag s=%0h r=%0h", s_out, r_out);
    a_gnt_oh:   assert property (@(negedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("FAIL sva_gnt_onehot gnt=%0h", gnt);
    a_done_oh:  assert property (@(negedge clk) disable iff (!rst_n) $onehot0(done))
        else $error("FAIL sva_done_onehot done=%0h", done);

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  op;
        logic [11:0] idx;
        logic [7:0]  stuck;
        logic [3:0]  e_gnt;
        logic [7:0]  e_s;
        logic [7:0]  e_r;
        logic        e_err;
        logic [7:0]  e_q;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // bank starts clear; single requester per vector so the pointer never matters
        vt[0] = '{4'b0001, 4'b0001, 12'(3),       8'h00, 4'b0001, 8'h08, 8'h00, 1'b0, 8'h08};
        vt[1] = '{4'b0100, 4'b0000, 12'(3) << 6,  8'h00, 4'b0100, 8'h00, 8'h08, 1'b0, 8'h00};
        vt[2] = '{4'b0010, 4'b0010, 12'(7) << 3,  8'h00, 4'b0010, 8'h80, 8'h00, 1'b0, 8'h80};
        vt[3] = '{4'b1000, 4'b1000, 12'(5) << 9,  8'h20, 4'b1000, 8'h20, 8'h00, 1'b1, 8'h80};
        vt[4] = '{4'b1000, 4'b0000, 12'(7) << 9,  8'h00, 4'b1000, 8'h00, 8'h80, 1'b0, 8'h20};

        rst_n = 1'b0;
        req = '0; op = '0; idx = '0; stuck0 = '0;
        req2 = '0; op2 = '0; idx2 = '0;
        #12;
        check("rst_gnt",  32'(gnt),   32'h0);
        check("rst_done", 32'(done),  32'h0);
        check("rst_err",  32'(err),   32'h0);
        check("rst_s",    32'(s_out), 32'h0);
        check("rst_r",    32'(r_out), 32'h0);
        check("rst_busy", 32'(busy),  32'h0);
        #10 rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        for (int v = 0; v < 5; v++) begin
            stuck0 = vt[v].stuck;
            req = vt[v].req; op = vt[v].op; idx = vt[v].idx;
            step();
            check($sformatf("v%0d_gnt", v),  32'(gnt),   32'(vt[v].e_gnt));
            check($sformatf("v%0d_s", v),    32'(s_out), 32'(vt[v].e_s));
            check($sformatf("v%0d_r", v),    32'(r_out), 32'(vt[v].e_r));
            check($sformatf("v%0d_busy", v), 32'(busy),  32'h1);
            req = '0;
            step();
            check($sformatf("v%0d_sr_off", v), 32'(s_out | r_out), 32'h0);
            check($sformatf("v%0d_gnt_off", v), 32'(gnt), 32'h0);
            step();
            check($sformatf("v%0d_done", v), 32'(done), 32'(vt[v].e_gnt));
            check($sformatf("v%0d_err", v),  32'(err),  32'(vt[v].e_err));
            check($sformatf("v%0d_q", v),    32'(q_in), 32'(vt[v].e_q));
        end
        stuck0 = '0;

        // fairness from a freshly reset pointer
        rst_n = 1'b0; #3 rst_n = 1'b1;
        req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int t = 0; t < 15; t++) begin
            step();
            if (t % 3 == 0) begin
                check($sformatf("fair_gnt_t%0d", t), 32'(gnt),   32'(4'b0001 << ((t / 3) % 4)));
                check($sformatf("fair_s_t%0d", t),   32'(s_out), 32'(8'h01 << ((t / 3) % 4)));
            end else begin
                check($sformatf("fair_gnt_t%0d", t), 32'(gnt), 32'h0);
            end
        end
        req = '0;
        step();

        // reset while driving the bank
        req = 4'b0001; op = 4'b0001; idx = 12'(2);
        step();
        check("mid_s_before", 32'(s_out), 32'h04);
        req = '0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_s_async",  32'(s_out), 32'h0);
        check("mid_r_async",  32'(r_out), 32'h0);
        check("mid_gnt_async", 32'(gnt),  32'h0);
        check("mid_busy",     32'(busy),  32'h0);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            check($sformatf("mid_no_done_%0d", t), 32'(done), 32'h0);
        end
        req = 4'b0010; op = 4'b0000; idx = 12'(1) << 3;
        step();
        check("post_rst_gnt", 32'(gnt), 32'h2);
        req = '0;
        step(); step();

        // inputs altered during CHECK must not affect the result
        req = 4'b0001; op = 4'b0001; idx = 12'(4);
        step();
        check("lat_s", 32'(s_out), 32'h10);
        req = '0;
        step();
        op = 4'b0000; idx = 12'(6);
        step();
        check("lat_done", 32'(done), 32'h1);
        check("lat_err",  32'(err),  32'h0);

        // requester 3 withdraws while requester 1 is being served
        req = 4'b1010; op = 4'b0000; idx = {3'd1, 3'd0, 3'd0, 3'd0};
        step();
        check("wd_gnt1", 32'(gnt), 32'h2);
        req = '0;
        step(); step();
        for (int t = 0; t < 3; t++) begin
            step();
            check($sformatf("wd_no_gnt_%0d", t), 32'(gnt), 32'h0);
            check($sformatf("wd_idle_%0d", t), 32'(busy), 32'h0);
        end

        // out-of-range index on a 5-flag bank
        req2 = 2'b01; op2 = 2'b01; idx2 = 6'd6;
        step();
        check("oor_gnt", 32'(gnt2), 32'h1);
        check("oor_s",   32'(s2),   32'h0);
        check("oor_r",   32'(r2),   32'h0);
        req2 = '0;
        step();
        check("oor_s_drive", 32'(s2 | r2), 32'h0);
        step();
        check("oor_done", 32'(done2), 32'h1);
        check("oor_err",  32'(err2),  32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
